// File: rtl/booth8_controller.sv
// Radix-8 Booth sequencer: captures a signed multiplier, runs one precompute
// cycle for 3A, then emits one recoded digit per cycle and a done pulse.
module booth8_controller #(
  parameter int k = 4,
  localparam int N = (k + 2) / 3,
  localparam int IW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [k-1:0]  x,
  output logic          busy,
  output logic          pre_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          shift_en,
  output logic [2:0]    digit_mag,
  output logic          digit_neg,
  output logic [IW-1:0] digit_idx,
  output logic          done
);

  localparam int W  = 3 * N + 1;
  localparam int XW = W - 1;

  typedef enum logic [1:0] {IDLE, PRE, SCAN, DONE} state_t;

  // Recode one overlapping group {b3,b2,b1,b0} into {neg, |d|}; zero is never negative.
  function automatic logic [3:0] booth_digit(input logic [3:0] g);
    logic [3:0] r;
    case (g)
      4'b0000: r = 4'b0_000;
      4'b0001: r = 4'b0_001;
      4'b0010: r = 4'b0_001;
      4'b0011: r = 4'b0_010;
      4'b0100: r = 4'b0_010;
      4'b0101: r = 4'b0_011;
      4'b0110: r = 4'b0_011;
      4'b0111: r = 4'b0_100;
      4'b1000: r = 4'b1_100;
      4'b1001: r = 4'b1_011;
      4'b1010: r = 4'b1_011;
      4'b1011: r = 4'b1_010;
      4'b1100: r = 4'b1_010;
      4'b1101: r = 4'b1_001;
      4'b1110: r = 4'b1_001;
      4'b1111: r = 4'b0_000;
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

  state_t          state_r;
  logic [W-1:0]    xr_r;
  logic [IW-1:0]   cnt_r;
  logic [XW-1:0]   xs_s;
  logic [3:0]      dig_s;

  assign xs_s  = XW'($signed(x));
  assign dig_s = booth_digit(xr_r[3:0]);

  // Sequencer; all outputs are registered. xr shifts down by 3 so group i is always in xr[3:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      xr_r      <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      pre_en    <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      shift_en  <= 1'b0;
      digit_mag <= 3'd0;
      digit_neg <= 1'b0;
      digit_idx <= '0;
      done      <= 1'b0;
    end else begin
      pre_en    <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      shift_en  <= 1'b0;
      digit_mag <= 3'd0;
      digit_neg <= 1'b0;
      digit_idx <= '0;
      done      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= PRE;
            xr_r    <= {xs_s, 1'b0};
            cnt_r   <= '0;
            busy    <= 1'b1;
            pre_en  <= 1'b1;
            acc_clr <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        PRE, SCAN: begin
          busy <= 1'b1;
          if (cnt_r == IW'(N)) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            state_r   <= SCAN;
            acc_en    <= 1'b1;
            shift_en  <= 1'b1;
            digit_neg <= dig_s[3];
            digit_mag <= dig_s[2:0];
            digit_idx <= cnt_r;
            cnt_r     <= cnt_r + IW'(1);
            xr_r      <= {{3{xr_r[W-1]}}, xr_r[W-1:3]};
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth8_controller.sv
// Scoreboard bench for booth8_controller: k=4 (directed + exhaustive) and k=8 (random) instances.
module tb_booth8_controller;

  typedef struct {
    int kind;   // 0 = PRE, 1 = digit, 2 = done
    int cyc;
    int d;
    int idx;
    int val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] x_a;
  logic [7:0] x_b;
  logic       busy_a, pre_en_a, acc_clr_a, acc_en_a, shift_en_a, digit_neg_a, done_a;
  logic [2:0] digit_mag_a;
  logic [1:0] digit_idx_a;
  logic       busy_b, pre_en_b, acc_clr_b, acc_en_b, shift_en_b, digit_neg_b, done_b;
  logic [2:0] digit_mag_b;
  logic [2:0] digit_idx_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   sum_v[2];
  exp_t qa[$];
  exp_t qb[$];

  booth8_controller #(.k(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x(x_a),
    .busy(busy_a), .pre_en(pre_en_a), .acc_clr(acc_clr_a), .acc_en(acc_en_a),
    .shift_en(shift_en_a), .digit_mag(digit_mag_a), .digit_neg(digit_neg_a),
    .digit_idx(digit_idx_a), .done(done_a)
  );

  booth8_controller #(.k(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x(x_b),
    .busy(busy_b), .pre_en(pre_en_b), .acc_clr(acc_clr_b), .acc_en(acc_en_b),
    .shift_en(shift_en_b), .digit_mag(digit_mag_b), .digit_neg(digit_neg_b),
    .digit_idx(digit_idx_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int bit_of(input int v, input int j);
    if (j < 0) return 0;
    return (v >>> j) & 1;
  endfunction

  // Booth digit i of v from the recoding definition.
  function automatic int bdig(input int v, input int i);
    return -4 * bit_of(v, 3*i+2) + 2 * bit_of(v, 3*i+1) + bit_of(v, 3*i) + bit_of(v, 3*i-1);
  endfunction

  task automatic push_exp(input int inst, input exp_t e);
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic push_op(input int inst, input int acc, input int xv, input int d0, input int d1, input int d2);
    exp_t e;
    int   nd;
    nd = (inst == 0) ? 2 : 3;
    e = '{kind: 0, cyc: acc, d: 0, idx: 0, val: 0};
    push_exp(inst, e);
    for (int i = 0; i < nd; i++) begin
      e = '{kind: 1, cyc: acc + 1 + i, d: (i == 0) ? d0 : ((i == 1) ? d1 : d2), idx: i, val: 0};
      push_exp(inst, e);
    end
    e = '{kind: 2, cyc: acc + nd + 1, d: 0, idx: 0, val: xv};
    push_exp(inst, e);
  endtask

  // Caller must be in an IDLE cycle; the next rising edge accepts.
  task automatic accept_op(input int inst, input int xv, input int d0, input int d1, input int d2);
    int acc;
    if (inst == 0) begin x_a = xv[3:0]; start_a = 1'b1; end
    else begin x_b = xv[7:0]; start_b = 1'b1; end
    @(posedge clk); #1;
    acc = cyc;
    if (inst == 0) start_a = 1'b0;
    else start_b = 1'b0;
    push_op(inst, acc, xv, d0, d1, d2);
  endtask

  task automatic drain(input int inst);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst == 0 && qa.size() == 0 && !busy_a) begin ok = 1'b1; break; end
      if (inst == 1 && qb.size() == 0 && !busy_b) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain[%0d]: pending %0d entries, required 0 within 40 cycles", inst,
               (inst == 0) ? qa.size() : qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    logic [29:0] got;
    got = {busy_a, pre_en_a, acc_clr_a, acc_en_a, shift_en_a, digit_mag_a, digit_neg_a, digit_idx_a, done_a,
           busy_b, pre_en_b, acc_clr_b, acc_en_b, shift_en_b, digit_mag_b, digit_neg_b, digit_idx_b, done_b,
           3'b000};
    checks++;
    if (got !== 30'd0) begin
      errors++;
      $display("FAIL %s: outputs %b, required all 0", name, got);
    end
  endtask

  task automatic mon_check(input int inst, input logic bsy, input logic pe, input logic ac, input logic ae,
                           input logic se, input int mag, input logic neg, input int idx, input logic dn);
    exp_t e;
    int   kind;
    int   d;
    logic act;
    act = pe | ae | dn;
    checks++;
    if (bsy !== act) begin
      errors++;
      $display("FAIL busy[%0d] cyc %0d: got %b, required %b", inst, cyc, bsy, act);
    end
    if (!act) begin
      checks++;
      if (mag != 0 || neg !== 1'b0 || idx != 0 || ac !== 1'b0 || se !== 1'b0) begin
        errors++;
        $display("FAIL idle_out[%0d] cyc %0d: mag %0d neg %b idx %0d clr %b sh %b, required zeros",
                 inst, cyc, mag, neg, idx, ac, se);
      end
      return;
    end
    kind = pe ? 0 : (ae ? 1 : 2);
    checks++;
    if (inst == 0 && qa.size() > 0) e = qa.pop_front();
    else if (inst == 1 && qb.size() > 0) e = qb.pop_front();
    else begin
      errors++;
      $display("FAIL unexpected[%0d] cyc %0d: got activity kind %0d, required none", inst, cyc, kind);
      return;
    end
    if (kind != e.kind || cyc != e.cyc) begin
      errors++;
      $display("FAIL order[%0d]: got kind %0d at cyc %0d, required kind %0d at cyc %0d", inst, kind, cyc, e.kind, e.cyc);
      return;
    end
    checks++;
    case (kind)
      0: begin
        sum_v[inst] = 0;
        if (ac !== 1'b1 || se !== 1'b0) begin
          errors++;
          $display("FAIL pre[%0d] cyc %0d: acc_clr %b shift_en %b, required 1 0", inst, cyc, ac, se);
        end
      end
      1: begin
        d = neg ? -mag : mag;
        sum_v[inst] += d * (8 ** idx);
        if (mag != ((e.d < 0) ? -e.d : e.d) || neg !== (e.d < 0) || idx != e.idx || se !== 1'b1 || ac !== 1'b0) begin
          errors++;
          $display("FAIL digit[%0d] cyc %0d: mag %0d neg %b idx %0d sh %b clr %b, required d %0d idx %0d",
                   inst, cyc, mag, neg, idx, se, ac, e.d, e.idx);
        end
      end
      default: begin
        if (sum_v[inst] != e.val) begin
          errors++;
          $display("FAIL sum[%0d] cyc %0d: digits sum %0d, required x %0d", inst, cyc, sum_v[inst], e.val);
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst) mon_check(0, busy_a, pre_en_a, acc_clr_a, acc_en_a, shift_en_a, int'(digit_mag_a),
                       digit_neg_a, int'(digit_idx_a), done_a);
  end

  always @(negedge clk) begin
    if (rst) mon_check(1, busy_b, pre_en_b, acc_clr_b, acc_en_b, shift_en_b, int'(digit_mag_b),
                       digit_neg_b, int'(digit_idx_b), done_b);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int xv;
    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b0;
    x_a = 4'b1010;
    x_b = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b1;
    accept_op(0, -6, 2, -1, 0);
    drain(0);

    // directed k=4 vectors, hand-recoded
    accept_op(0, 3, 3, 0, 0);   drain(0);
    accept_op(0, -7, 1, -1, 0); drain(0);
    accept_op(0, -8, 0, -1, 0); drain(0);
    accept_op(0, 7, -1, 1, 0);  drain(0);

    // start and x changes while busy are ignored
    accept_op(0, -3, -3, 0, 0);
    @(negedge clk); start_a = 1'b1; x_a = 4'd5;
    @(negedge clk);
    @(negedge clk); start_a = 1'b0;
    drain(0);

    // start held high: operations every 5 cycles
    x_a = 4'd3; start_a = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    push_op(0, acc, 3, 3, 0, 0);
    push_op(0, acc + 5, 3, 3, 0, 0);
    push_op(0, acc + 10, 3, 3, 0, 0);
    repeat (10) @(posedge clk);
    #1 start_a = 1'b0;
    drain(0);

    // async reset during digit 0 abandons the operation
    accept_op(0, 3, 3, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero("reset_mid_scan");
    qa.delete();
    @(negedge clk); rst = 1'b1;
    repeat (6) @(negedge clk);
    accept_op(0, -8, 0, -1, 0);
    drain(0);

    // exhaustive k=4
    for (int v = -8; v < 8; v++) begin
      accept_op(0, v, bdig(v, 0), bdig(v, 1), 0);
      drain(0);
    end

    // k=8 boundaries and random sweep
    for (int j = 0; j < 22; j++) begin
      if (j == 0) xv = -128;
      else if (j == 1) xv = 127;
      else begin
        xv = int'($urandom_range(0, 255));
        if (xv >= 128) xv = xv - 256;
      end
      accept_op(1, xv, bdig(xv, 0), bdig(xv, 1), bdig(xv, 2));
      drain(1);
    end

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d/%0d entries, required 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
